// File: rtl/river_crossing_ctrl.sv
// River-crossing puzzle controller: a move or undo request is applied on the clock edge that sees its rising edge; Lost/Won follow one edge later; requests are never stalled.
// Optional one-deep undo history is compiled in when RCC_UNDO_EN is defined.
module river_crossing_ctrl #(
  parameter int MAX_MOVES = 99
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       move,
  input  logic [1:0] sel,
  input  logic       undo,
  input  logic       alarm,
  output logic       farmer,
  output logic       cabbage,
  output logic       goat,
  output logic       wolf,
  output logic       lost,
  output logic       won,
  output logic       illegal,
  output logic [6:0] moves
);

  localparam logic [6:0] MovesMax = 7'(MAX_MOVES);

  typedef enum logic [1:0] {PLAY, LOST, WON} state_t;

  state_t     state_q, state_d;
  logic [3:0] pos_q, pos_d;  // {farmer, cabbage, goat, wolf}
  logic [6:0] moves_q, moves_d;
  logic       illegal_q, illegal_d;
  logic       move_q;
  logic       move_req;
  logic       item_pos;
  logic       legal;
  logic [3:0] toggle;

  assign move_req = move & ~move_q;

  always_comb begin
    item_pos = pos_q[3];
    toggle   = 4'b1000;
    case (sel)
      2'b01:   begin item_pos = pos_q[2]; toggle = 4'b1100; end
      2'b10:   begin item_pos = pos_q[1]; toggle = 4'b1010; end
      2'b11:   begin item_pos = pos_q[0]; toggle = 4'b1001; end
      default: begin item_pos = pos_q[3]; toggle = 4'b1000; end
    endcase
  end

  // Passengers may only board on the farmer's bank.
  assign legal = (sel == 2'b00) || (item_pos == pos_q[3]);

`ifdef RCC_UNDO_EN
  logic       undo_q;
  logic       undo_req;
  logic       hist_vld_q, hist_vld_d;
  logic [3:0] hist_pos_q, hist_pos_d;
  logic [6:0] hist_moves_q, hist_moves_d;

  assign undo_req = undo & ~undo_q;
`else
  logic unused_undo;
  assign unused_undo = undo;
`endif

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    moves_d   = moves_q;
    illegal_d = 1'b0;
`ifdef RCC_UNDO_EN
    hist_vld_d   = hist_vld_q;
    hist_pos_d   = hist_pos_q;
    hist_moves_d = hist_moves_q;
    // Undo outranks both a simultaneous move and the alarm check.
    if (undo_req && (state_q != WON)) begin
      if (hist_vld_q) begin
        pos_d      = hist_pos_q;
        moves_d    = hist_moves_q;
        hist_vld_d = 1'b0;
        state_d    = PLAY;
      end else begin
        illegal_d = 1'b1;
      end
    end else
`endif
    if (state_q == PLAY) begin
      if (alarm) begin
        state_d = LOST;
      end else if (&pos_q) begin
        state_d = WON;
      end else if (move_req) begin
        if (legal) begin
          pos_d = pos_q ^ toggle;
          if (moves_q < MovesMax) begin
            moves_d = moves_q + 7'd1;
          end
`ifdef RCC_UNDO_EN
          hist_vld_d   = 1'b1;
          hist_pos_d   = pos_q;
          hist_moves_d = moves_q;
`endif
        end else begin
          illegal_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= PLAY;
      pos_q     <= 4'b0000;
      moves_q   <= 7'd0;
      illegal_q <= 1'b0;
      // History of 1 means a level held through reset is not a request.
      move_q    <= 1'b1;
`ifdef RCC_UNDO_EN
      undo_q       <= 1'b1;
      hist_vld_q   <= 1'b0;
      hist_pos_q   <= 4'b0000;
      hist_moves_q <= 7'd0;
`endif
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      moves_q   <= moves_d;
      illegal_q <= illegal_d;
      move_q    <= move;
`ifdef RCC_UNDO_EN
      undo_q       <= undo;
      hist_vld_q   <= hist_vld_d;
      hist_pos_q   <= hist_pos_d;
      hist_moves_q <= hist_moves_d;
`endif
    end
  end

  assign farmer  = pos_q[3];
  assign cabbage = pos_q[2];
  assign goat    = pos_q[1];
  assign wolf    = pos_q[0];
  assign lost    = (state_q == LOST);
  assign won     = (state_q == WON);
  assign illegal = illegal_q;
  assign moves   = moves_q;

endmodule

// File: tb/tb_river_crossing_ctrl.sv
// Bench for river_crossing_ctrl: directed puzzle scenarios plus random play against a rule-level model.
module tb_river_crossing_ctrl;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       move = 1'b0;
  logic [1:0] sel = 2'b00;
  logic       undo = 1'b0;
  logic       alarm_force = 1'b0;
  logic       alarm;
  logic       farmer, cabbage, goat, wolf;
  logic       lost, won, illegal;
  logic [6:0] moves;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  // Downstream safety checker: goat left with cabbage or wolf without the farmer.
  assign alarm = alarm_force |
                 ((goat == cabbage) && (goat != farmer)) |
                 ((goat == wolf) && (goat != farmer));

  river_crossing_ctrl #(.MAX_MOVES(99)) dut (
    .clock   (clock),
    .resetn  (resetn),
    .move    (move),
    .sel     (sel),
    .undo    (undo),
    .alarm   (alarm),
    .farmer  (farmer),
    .cabbage (cabbage),
    .goat    (goat),
    .wolf    (wolf),
    .lost    (lost),
    .won     (won),
    .illegal (illegal),
    .moves   (moves)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    move = 1'b0;
    undo = 1'b0;
    alarm_force = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic pulse(input logic [1:0] s);
    sel = s;
    move = 1'b1;
    tick();
    move = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    move = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({farmer, cabbage, goat, wolf} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_pos got %b want 0000", {farmer, cabbage, goat, wolf});
    end
    n_checks++;
    if ({lost, won, illegal, moves} !== 10'd0) begin
      n_fail++; $display("FAIL reset_flags got lost=%b won=%b ill=%b moves=%0d want all 0", lost, won, illegal, moves);
    end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_goat_move();
    do_reset();
    pulse(2'b10);
    n_checks++;
    if ({farmer, cabbage, goat, wolf} !== 4'b1010 || moves !== 7'd1) begin
      n_fail++; $display("FAIL goat_move got pos=%b moves=%0d want pos=1010 moves=1", {farmer, cabbage, goat, wolf}, moves);
    end
    n_checks++;
    if (lost !== 1'b0 || won !== 1'b0) begin
      n_fail++; $display("FAIL goat_move_flags got lost=%b won=%b want 0 0", lost, won);
    end
  endtask

  task automatic test_illegal();
    sel = 2'b11;
    move = 1'b1;
    tick();
    n_checks++;
    if (illegal !== 1'b1) begin
      n_fail++; $display("FAIL illegal_pulse got %b want 1", illegal);
    end
    move = 1'b0;
    tick();
    n_checks++;
    if (illegal !== 1'b0) begin
      n_fail++; $display("FAIL illegal_end got %b want 0", illegal);
    end
    n_checks++;
    if ({farmer, cabbage, goat, wolf} !== 4'b1010 || moves !== 7'd1) begin
      n_fail++; $display("FAIL illegal_hold got pos=%b moves=%0d want pos=1010 moves=1", {farmer, cabbage, goat, wolf}, moves);
    end
  endtask

  task automatic test_lost();
    do_reset();
    sel = 2'b01;
    move = 1'b1;
    tick();
    alarm_force = 1'b1;
    n_checks++;
    if ({farmer, cabbage, goat, wolf} !== 4'b1100 || lost !== 1'b0) begin
      n_fail++; $display("FAIL lost_move got pos=%b lost=%b want pos=1100 lost=0", {farmer, cabbage, goat, wolf}, lost);
    end
    move = 1'b0;
    tick();
    n_checks++;
    if (lost !== 1'b1 || won !== 1'b0) begin
      n_fail++; $display("FAIL lost_flag got lost=%b won=%b want 1 0", lost, won);
    end
    sel = 2'b00;
    move = 1'b1;
    tick();
    n_checks++;
    if (illegal !== 1'b0) begin
      n_fail++; $display("FAIL lost_no_illegal got %b want 0", illegal);
    end
    move = 1'b0;
    tick();
    n_checks++;
    if ({farmer, cabbage, goat, wolf} !== 4'b1100 || moves !== 7'd1 || lost !== 1'b1) begin
      n_fail++; $display("FAIL lost_hold got pos=%b moves=%0d lost=%b want 1100 1 1", {farmer, cabbage, goat, wolf}, moves, lost);
    end
  endtask

  task automatic test_win();
    logic [1:0] seq [7];
    seq = '{2'b10, 2'b00, 2'b11, 2'b10, 2'b01, 2'b00, 2'b10};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      pulse(seq[i]);
      n_checks++;
      if (lost !== 1'b0) begin
        n_fail++; $display("FAIL win_no_lost step %0d got lost=%b want 0", i, lost);
      end
    end
    n_checks++;
    if ({farmer, cabbage, goat, wolf} !== 4'b1111 || won !== 1'b1 || moves !== 7'd7) begin
      n_fail++; $display("FAIL win_end got pos=%b won=%b moves=%0d want 1111 1 7", {farmer, cabbage, goat, wolf}, won, moves);
    end
    sel = 2'b10;
    move = 1'b1;
    tick();
    n_checks++;
    if (illegal !== 1'b0 || goat !== 1'b1 || moves !== 7'd7 || won !== 1'b1) begin
      n_fail++; $display("FAIL win_hold got ill=%b goat=%b moves=%0d won=%b want 0 1 7 1", illegal, goat, moves, won);
    end
    move = 1'b0;
    tick();
  endtask

  task automatic test_move_held_reset();
    resetn = 1'b0;
    move = 1'b1;
    sel = 2'b10;
    tick();
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if ({farmer, cabbage, goat, wolf} !== 4'b0000 || moves !== 7'd0 || illegal !== 1'b0) begin
      n_fail++; $display("FAIL held_reset got pos=%b moves=%0d ill=%b want 0000 0 0", {farmer, cabbage, goat, wolf}, moves, illegal);
    end
    move = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 105; i++) begin
      pulse(2'b10);
      if (i == 98) begin
        n_checks++;
        if (moves !== 7'd99) begin
          n_fail++; $display("FAIL sat_reach got %0d want 99", moves);
        end
      end
    end
    n_checks++;
    if (moves !== 7'd99 || farmer !== 1'b1 || goat !== 1'b1 || lost !== 1'b0) begin
      n_fail++; $display("FAIL sat_hold got moves=%0d f=%b g=%b lost=%b want 99 1 1 0", moves, farmer, goat, lost);
    end
  endtask

`ifdef RCC_UNDO_EN
  task automatic test_undo();
    test_lost();
    alarm_force = 1'b0;
    undo = 1'b1;
    tick();
    undo = 1'b0;
    tick();
    n_checks++;
    if ({farmer, cabbage, goat, wolf} !== 4'b0000 || moves !== 7'd0 || lost !== 1'b0) begin
      n_fail++; $display("FAIL undo_restore got pos=%b moves=%0d lost=%b want 0000 0 0", {farmer, cabbage, goat, wolf}, moves, lost);
    end
    undo = 1'b1;
    tick();
    n_checks++;
    if (illegal !== 1'b1) begin
      n_fail++; $display("FAIL undo_empty got ill=%b want 1", illegal);
    end
    undo = 1'b0;
    tick();
  endtask
`else
  task automatic test_undo_ignored();
    do_reset();
    pulse(2'b10);
    undo = 1'b1;
    tick();
    n_checks++;
    if (illegal !== 1'b0) begin
      n_fail++; $display("FAIL undo_off_illegal got %b want 0", illegal);
    end
    undo = 1'b0;
    tick();
    n_checks++;
    if ({farmer, cabbage, goat, wolf} !== 4'b1010 || moves !== 7'd1) begin
      n_fail++; $display("FAIL undo_off_hold got pos=%b moves=%0d want 1010 1", {farmer, cabbage, goat, wolf}, moves);
    end
  endtask
`endif

  // Rule-level model: index 0 farmer, 1 cabbage, 2 goat, 3 wolf (matches Sel code).
  task automatic test_random();
    int  m_pos [4];
    int  m_moves, m_over;  // m_over: 0 playing, 1 eaten, 2 everyone across
    bit  m_prev, m_ill, rise, unsafe;
    int  bad;
    m_prev = 1'b1;
    alarm_force = 1'b0;
    undo = 1'b0;
    m_over = 0;
    bad = 0;
    for (int c = 0; c < 1500; c++) begin
      resetn = !((c == 0) || ($urandom_range(0, 59) == 0) || (m_over != 0 && $urandom_range(0, 3) == 0));
      move   = 1'($urandom_range(0, 1));
      sel    = 2'($urandom_range(0, 3));
      if (!resetn) begin
        foreach (m_pos[j]) m_pos[j] = 0;
        m_moves = 0; m_over = 0; m_ill = 1'b0; m_prev = 1'b1;
      end else begin
        rise = move && !m_prev;
        m_prev = move;
        m_ill = 1'b0;
        unsafe = (m_pos[2] == m_pos[1] && m_pos[2] != m_pos[0]) ||
                 (m_pos[2] == m_pos[3] && m_pos[2] != m_pos[0]);
        if (m_over == 0) begin
          if (unsafe) m_over = 1;
          else if (m_pos[0] + m_pos[1] + m_pos[2] + m_pos[3] == 4) m_over = 2;
          else if (rise) begin
            if (sel == 0 || m_pos[sel] == m_pos[0]) begin
              m_pos[0] = 1 - m_pos[0];
              if (sel != 0) m_pos[sel] = 1 - m_pos[sel];
              if (m_moves < 99) m_moves++;
            end else begin
              m_ill = 1'b1;
            end
          end
        end
      end
      tick();
      n_checks++;
      if (farmer !== 1'(m_pos[0]) || cabbage !== 1'(m_pos[1]) || goat !== 1'(m_pos[2]) ||
          wolf !== 1'(m_pos[3]) || moves !== 7'(m_moves) || illegal !== m_ill ||
          lost !== (m_over == 1) || won !== (m_over == 2)) begin
        n_fail++;
        if (bad < 10) $display("FAIL random cycle %0d got pos=%b moves=%0d ill=%b lost=%b won=%b want pos=%0d%0d%0d%0d moves=%0d ill=%b over=%0d",
                               c, {farmer, cabbage, goat, wolf}, moves, illegal, lost, won,
                               m_pos[0], m_pos[1], m_pos[2], m_pos[3], m_moves, m_ill, m_over);
        bad++;
      end
    end
    move = 1'b0;
  endtask

  initial begin
    test_reset();
    test_goat_move();
    test_illegal();
    test_lost();
    test_win();
    test_move_held_reset();
    test_saturation();
`ifdef RCC_UNDO_EN
    test_undo();
`else
    test_undo_ignored();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/river_crossing_ctrl.md
RIVER_CROSSING_CTRL -- requirements
Module: river_crossing_ctrl

Interface
REQ-001 The block SHALL have parameter MAX_MOVES, default 99, giving the saturation value of Moves.
REQ-002 Clock  in  1  the single clock; all state updates on its rising edge.
REQ-003 Resetn  in  1  synchronous, active-low reset.
REQ-004 Move  in  1  crossing request (level); only a rising edge (sampled 1, previous sample 0) is a request.
REQ-005 Sel  in  2  passenger: 00 farmer alone, 01 Cabbage, 10 Goat, 11 Wolf.
REQ-006 Undo  in  1  undo request (rising edge); ignored unless RCC_UNDO_EN is defined.
REQ-007 Alarm  in  1  unsafe-state flag from the downstream checker, combinational on {Farmer,Cabbage,Goat,Wolf}.
REQ-008 Farmer, Cabbage, Goat, Wolf  out  1 each  registered bank positions (0 start bank, 1 far bank); they drive the downstream checker.
REQ-009 Lost  out  1  level, high in LOST.
REQ-010 Won  out  1  level, high in WON.
REQ-011 Illegal  out  1  one-cycle pulse on a rejected request.
REQ-012 Moves  out  7  accepted-move count, binary.

Function
REQ-013 The FSM SHALL have states PLAY, LOST and WON; reset enters PLAY.
REQ-014 Timing: in PLAY, a Move edge detected at clock edge k SHALL be evaluated and applied at edge k; a legal request SHALL update positions at edge k.
REQ-015 A request SHALL be legal when Sel=00, or when the selected item's bit equals Farmer.
REQ-016 Accepted request: Farmer toggles, the selected item (if any) toggles, and Moves increments, saturating at MAX_MOVES while moves are still accepted.
REQ-017 Rejected request: positions and Moves unchanged; Illegal is high for exactly the cycle after edge k.
REQ-018 In PLAY at each edge: Alarm=1 SHALL go to LOST; otherwise {1,1,1,1} positions SHALL go to WON; otherwise remain in PLAY.
REQ-019 LOST SHALL take priority over WON; a Move edge at the same edge as a LOST/WON transition SHALL be dropped.
REQ-020 Lost/Won SHALL assert at edge k+1 after the move applied at edge k.
REQ-021 In LOST and WON, Move edges SHALL be ignored (no Illegal pulse), and positions and Moves SHALL hold.
REQ-022 Move held high across reset release SHALL NOT produce a request; the edge-detect history resets to 1.

Reset
REQ-023 While Resetn=0 at an edge: Farmer=Cabbage=Goat=Wolf=0, Lost=0, Won=0, Illegal=0, Moves=0, state PLAY, undo history invalid.
REQ-024 Reset SHALL abort any operation in any state, with no partial update.

Configuration
REQ-025 With RCC_UNDO_EN defined: each accepted move saves the prior positions and Moves in a one-deep history and marks it valid.
REQ-026 With RCC_UNDO_EN defined: an Undo edge in PLAY or LOST with valid history SHALL restore the positions and Moves, clear the history, and enter PLAY.
REQ-027 With RCC_UNDO_EN defined: an Undo edge with invalid history SHALL pulse Illegal; an Undo edge in WON SHALL be ignored.
REQ-028 With RCC_UNDO_EN defined: Undo SHALL take priority over a simultaneous Move edge, and the Move edge SHALL be dropped.
REQ-029 Without RCC_UNDO_EN: there is no history logic, and Undo SHALL have no effect.

Verification
REQ-030 Reset; Sel=10, Move pulse -> positions F,C,G,W=1,0,1,0; Moves=1; Lost=0; Won=0.
REQ-031 Reset; Sel=01, Move pulse -> positions 1,1,0,0; Alarm=1 -> Lost=1 one cycle later; a further Move pulse leaves positions and Moves unchanged.
REQ-032 After REQ-030, Sel=11, Move pulse (Wolf not with farmer) -> Illegal pulses 1 cycle; positions 1,0,1,0 and Moves=1 hold.
REQ-033 Sequence Goat, alone, Wolf, Goat, Cabbage, alone, Goat -> positions 1,1,1,1; Won=1; Moves=7; Lost never asserts.
REQ-034 Move held high through reset release, then held high for 5 cycles -> no position change; Moves=0.
REQ-035 RCC_UNDO_EN: after REQ-031 reaches LOST, Undo pulse -> positions 0,0,0,0; Moves=0; Lost=0; a second Undo pulse -> Illegal pulse.
